// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch MM:SS counting core.
// Digits are BCD nibbles; each field wraps at TENS_MAX:ONES_MAX (59).
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam bcd_t TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_counter_bcd.sv
// Two-digit BCD mod-60 counter; digits registered, carry is combinational and
// marks the 59 -> 00 wrap on the edge that performs it.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic clk_m,
    input  logic rst,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry
);

    bcd_t tens_q, ones_q;
    bcd_t tens_d, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        carry  = inc && (ones_q == ONES_MAX) && (tens_q == TENS_MAX);
        if (inc) begin
            if (ones_q == ONES_MAX) begin
                ones_d = 4'd0;
                tens_d = (tens_q == TENS_MAX) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_m or posedge rst) begin
        if (rst) begin
            tens_q <= 4'd0;
            ones_q <= 4'd0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS core: run/pause/adjust FSM driving two BCD mod-60 fields.
// Define STOPWATCH_BLINK_EN to build the adjust-mode blink masks; otherwise they read 0.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic       clk_m,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       blank_min,
    output logic       blank_sec
);

    state_t state_q;
    logic   run_saved_q;
    logic   running_q;
    logic   adj_step;
    logic   sec_inc, min_inc, sec_carry, min_carry;

    // A tick coinciding with the adj rise is dropped so the adjust entry is clean.
    assign adj_step = (state_q == ST_ADJUST) && tick_2hz;
    assign sec_inc  = ((state_q == ST_RUN) && tick_1hz && !adj) || (adj_step && sel);
    assign min_inc  = (state_q == ST_RUN) ? sec_carry : (adj_step && !sel);

    bcd_mod60 u_sec (
        .clk_m (clk_m),
        .rst   (rst),
        .inc   (sec_inc),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry)
    );

    bcd_mod60 u_min (
        .clk_m (clk_m),
        .rst   (rst),
        .inc   (min_inc),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry)
    );

    always_ff @(posedge clk_m or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            run_saved_q <= 1'b1;
            running_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (adj) begin
                        state_q     <= ST_ADJUST;
                        run_saved_q <= ~pause_p;
                        running_q   <= 1'b0;
                    end else if (pause_p) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (adj) begin
                        state_q     <= ST_ADJUST;
                        run_saved_q <= pause_p;
                    end else if (pause_p) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_ADJUST: begin
                    run_saved_q <= run_saved_q ^ pause_p;
                    if (!adj) begin
                        state_q   <= (run_saved_q ^ pause_p) ? ST_RUN : ST_PAUSED;
                        running_q <= run_saved_q ^ pause_p;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                end
            endcase
        end
    end

    assign running = running_q;

`ifdef STOPWATCH_BLINK_EN
    logic sel_q, blank_min_q, blank_sec_q;

    always_ff @(posedge clk_m or posedge rst) begin
        if (rst) begin
            sel_q       <= 1'b0;
            blank_min_q <= 1'b0;
            blank_sec_q <= 1'b0;
        end else begin
            sel_q <= sel;
            if ((state_q != ST_ADJUST) || !adj || (sel != sel_q)) begin
                blank_min_q <= 1'b0;
                blank_sec_q <= 1'b0;
            end else if (tick_2hz) begin
                blank_min_q <= sel ? 1'b0 : ~blank_min_q;
                blank_sec_q <= sel ? ~blank_sec_q : 1'b0;
            end
        end
    end

    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;
`else
    assign blank_min = 1'b0;
    assign blank_sec = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter; digits compared as a
// packed 16-bit MMSS BCD value. Inputs driven and outputs sampled on negedges.
module tb_stopwatch_counter;

    logic       clk_m = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0, tick_2hz = 1'b0, pause_p = 1'b0;
    logic       adj = 1'b0, sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, blank_min, blank_sec;

    int errors = 0;
    int checks = 0;

    always #5 clk_m = ~clk_m;

    stopwatch_counter dut (
        .clk_m     (clk_m),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .pause_p   (pause_p),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .running   (running),
        .blank_min (blank_min),
        .blank_sec (blank_sec)
    );

    wire [15:0] digits = {min_tens, min_ones, sec_tens, sec_ones};

    // One clock with the given pulses applied, then pulses cleared.
    task automatic cyc(input logic t1, input logic t2, input logic pp);
        tick_1hz = t1;
        tick_2hz = t2;
        pause_p  = pp;
        @(negedge clk_m);
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause_p  = 1'b0;
    endtask

    task automatic ticks1(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic steps2(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        adj = 1'b0;
        sel = 1'b0;
        @(negedge clk_m);
        rst = 1'b0;
        @(negedge clk_m);
    endtask

    // Preload MM:SS via adjust, returning to RUN.
    task automatic preload(input int mm, input int ss);
        adj = 1'b1;
        sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        steps2(mm);
        sel = 1'b1;
        steps2(ss);
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk_m);
        @(negedge clk_m);
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL reset_digits: got %h want 0000", digits);
        end
        checks++;
        if (running !== 1'b1 || blank_min !== 1'b0 || blank_sec !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: running=%b blank_min=%b blank_sec=%b want 1 0 0",
                     running, blank_min, blank_sec);
        end
        rst = 1'b0;
        @(negedge clk_m);
    endtask

    task automatic test_count;
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if (digits !== 16'h0001) begin
            errors++;
            $display("FAIL count_latency: got %h want 0001", digits);
        end
        ticks1(74);
        checks++;
        if (digits !== 16'h0115 || running !== 1'b1) begin
            errors++;
            $display("FAIL count_75: got %h running=%b want 0115 running=1", digits, running);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        preload(59, 58);
        checks++;
        if (digits !== 16'h5958 || running !== 1'b1) begin
            errors++;
            $display("FAIL preload_5958: got %h running=%b want 5958 running=1", digits, running);
        end
        ticks1(1);
        checks++;
        if (digits !== 16'h5959) begin
            errors++;
            $display("FAIL wrap_first: got %h want 5959", digits);
        end
        ticks1(1);
        checks++;
        if (digits !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_full: got %h want 0000", digits);
        end
    endtask

    task automatic test_pause;
        do_reset();
        ticks1(7);
        cyc(1'b0, 1'b0, 1'b1);
        ticks1(10);
        checks++;
        if (digits !== 16'h0007 || running !== 1'b0) begin
            errors++;
            $display("FAIL pause_hold: got %h running=%b want 0007 running=0", digits, running);
        end
        cyc(1'b0, 1'b0, 1'b1);
        ticks1(1);
        checks++;
        if (digits !== 16'h0008 || running !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got %h running=%b want 0008 running=1", digits, running);
        end
    endtask

    task automatic test_adjust;
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        steps2(61);
        checks++;
        if (digits !== 16'h0100 || running !== 1'b0) begin
            errors++;
            $display("FAIL adj_min61: got %h running=%b want 0100 running=0", digits, running);
        end
        ticks1(3);
        checks++;
        if (digits !== 16'h0100) begin
            errors++;
            $display("FAIL adj_ignore_1hz: got %h want 0100", digits);
        end
        sel = 1'b1;
        steps2(59);
        checks++;
        if (digits !== 16'h0159) begin
            errors++;
            $display("FAIL adj_sec59: got %h want 0159", digits);
        end
        steps2(1);
        checks++;
        if (digits !== 16'h0100) begin
            errors++;
            $display("FAIL adj_sec_nocarry: got %h want 0100", digits);
        end
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        ticks1(1);
        checks++;
        if (digits !== 16'h0101 || running !== 1'b1) begin
            errors++;
            $display("FAIL adj_exit_run: got %h running=%b want 0101 running=1", digits, running);
        end
    endtask

    task automatic test_same_edge;
        do_reset();
        ticks1(4);
        cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (digits !== 16'h0005 || running !== 1'b0) begin
            errors++;
            $display("FAIL tick_pause_edge: got %h running=%b want 0005 running=0", digits, running);
        end
        cyc(1'b0, 1'b0, 1'b1);
        adj = 1'b1;
        cyc(1'b1, 1'b0, 1'b1);
        checks++;
        if (digits !== 16'h0005 || running !== 1'b0) begin
            errors++;
            $display("FAIL adj_rise_tick: got %h running=%b want 0005 running=0", digits, running);
        end
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        ticks1(2);
        checks++;
        if (digits !== 16'h0005 || running !== 1'b0) begin
            errors++;
            $display("FAIL adj_pause_exit: got %h running=%b want 0005 running=0", digits, running);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        preload(12, 34);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (digits !== 16'h0000 || running !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got %h running=%b want 0000 running=1", digits, running);
        end
        #1 rst = 1'b0;
        @(negedge clk_m);
        ticks1(1);
        checks++;
        if (digits !== 16'h0001) begin
            errors++;
            $display("FAIL post_reset_tick: got %h want 0001", digits);
        end
    endtask

    task automatic test_blink;
        logic exp_sec;
        do_reset();
        adj = 1'b1;
        sel = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        exp_sec = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
`ifdef STOPWATCH_BLINK_EN
            exp_sec = ~exp_sec;
`endif
            checks++;
            if (blank_sec !== exp_sec || blank_min !== 1'b0) begin
                errors++;
                $display("FAIL blink_step%0d: blank_sec=%b blank_min=%b want %b 0",
                         i, blank_sec, blank_min, exp_sec);
            end
        end
        sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if (blank_sec !== 1'b0 || blank_min !== 1'b0) begin
            errors++;
            $display("FAIL blink_sel_clear: blank_sec=%b blank_min=%b want 0 0", blank_sec, blank_min);
        end
        adj = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk_m);
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_adjust();
        test_same_edge();
        test_reset_mid();
        test_blink();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

BCD minutes:seconds counting core of the stopwatch, directly upstream of the four-digit 7-segment display scanner. It advances a MM:SS value on a 1 Hz enable pulse, supports pause and a field-adjust mode that steps the selected field at 2 Hz, and presents four BCD digits that the display stage multiplexes. All enables come from the shared clock divider; no derived clocks are used inside the block.

## Interface
- No parameters. Limits are fixed constants in the package.
- clk_m  in  1  master clock; every register uses its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick_1hz  in  1  one-cycle enable pulse, 1 Hz, for counting.
- tick_2hz  in  1  one-cycle enable pulse, 2 Hz, for adjust stepping.
- pause_p  in  1  debounced one-cycle pulse that toggles run/pause.
- adj  in  1  level; 1 selects adjust mode.
- sel  in  1  level; in adjust mode 0 selects minutes, 1 selects seconds.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits; feed the display.
- running  out  1  1 while in RUN.
- blank_min, blank_sec  out  1 each  blink masks for the display (see Configuration).

## Operation
- States: RUN, PAUSED, ADJUST. Reset -> RUN, all digits 0, run_saved=1.
- RUN: on tick_1hz, seconds increment; sec 59 -> 00 with carry into minutes; min 59 -> 00 (59:59 -> 00:00). pause_p -> PAUSED.
- PAUSED: digits hold. pause_p -> RUN.
- ADJUST entered from RUN or PAUSED while adj=1; run_saved records the source (1=RUN). tick_1hz ignored. On tick_2hz the selected field increments by 1, 59 -> 00, no carry into the other field. pause_p in ADJUST toggles run_saved. adj=0 -> RUN if run_saved else PAUSED.
- adj has priority over pause_p in the same cycle: enter ADJUST, and the pulse toggles run_saved.
- Digits always legal BCD: ones 0-9, tens 0-5. Each field is a mod-60 two-digit BCD counter; carry only when ones=9 and tens=5.
- sel change during ADJUST takes effect on the next tick_2hz; no partial update.

## Timing
- Every output is registered. Reset values: all digits 0, running=1, blank_min=0, blank_sec=0.
- Count latency: tick_1hz sampled high at edge N -> new digits visible after edge N.
- State transitions take effect at the edge sampling the input. Counting at edge N uses the state held before edge N. tick_1hz together with pause_p in RUN still counts that tick, then enters PAUSED.
- tick_1hz on the same edge as the adj rise is ignored.
- Reset asserted mid-count clears asynchronously. The first tick after release counts from 00:00.

## Configuration
- STOPWATCH_BLINK_EN defined: in ADJUST, the mask of the selected field (blank_min when sel=0, blank_sec when sel=1) toggles on every tick_2hz. The unselected mask is 0. Both masks clear on leaving ADJUST or on sel change.
- Not defined: blank_min and blank_sec are tied to 0. No blink register is built.

## Structure
- Package stopwatch_pkg: state enum (RUN, PAUSED, ADJUST), constants TENS_MAX=5, ONES_MAX=9, BCD digit typedef (4 bits).
- Sub-module bcd_mod60 (inputs clk_m, rst, inc; outputs tens, ones, carry). It is instantiated twice, once for seconds and once for minutes. The minutes inc is the seconds carry in RUN, or the adjust step in ADJUST.

## Test plan
- Reset, 75 tick_1hz -> digits 0,1,1,5 (01:15), running=1.
- Preload 59:58 via adjust, 2 tick_1hz in RUN -> 00:00 on the second tick.
- pause_p, 10 tick_1hz -> digits unchanged, running=0. pause_p again, 1 tick -> +1 s.
- adj=1 sel=0 from 00:00, 61 tick_2hz -> min 01, sec 00 untouched. Same with sel=1 at 00:59, 1 step -> 00:00, minutes unchanged.
- tick_1hz and pause_p on the same edge in RUN -> count +1 and PAUSED. adj=1 with pause_p from RUN, then adj=0 -> PAUSED.
- rst pulsed between ticks at 12:34 -> 00:00 immediately, running=1. With STOPWATCH_BLINK_EN defined, in ADJUST with sel=1, blank_sec toggles each tick_2hz and blank_min stays 0.
